// File: rtl/apuf_eval_ctrl.sv
// apuf_eval_ctrl
//   Evaluation controller that sits directly in front of an arbiter-PUF
//   switch chain. It accepts one challenge, applies it to both select buses,
//   and launches the shared trigger NEVAL times. After each launch it samples
//   the arbiter output through a 2-flop synchronizer. It then returns the
//   majority vote of those samples along with the number of 1s seen.
//
// Ports
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   chal_valid/chal_ready    challenge handshake (ready only while idle)
//   chal                     challenge bits, captured on accept
//   cT, cB                   top/bottom stage selects (identical copies)
//   trig                     launch pulse fanned to inT and inB
//   arb_in                   arbiter latch output, asynchronous to clk
//   resp_valid/resp_ready    response handshake
//   resp                     majority-voted response bit
//   resp_ones                number of evaluations that sampled 1
//   resp_stable              (STABILITY_FLAG_EN only) all evaluations agreed
//
// Optional feature macro: STABILITY_FLAG_EN
module apuf_eval_ctrl #(
    parameter int NSTAGE    = 16,
    parameter int NEVAL     = 7,
    parameter int RESET_CYC = 4,
    parameter int SETTLE    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       chal_valid,
    output logic                       chal_ready,
    input  logic [NSTAGE-1:0]          chal,
    output logic [NSTAGE-1:0]          cT,
    output logic [NSTAGE-1:0]          cB,
    output logic                       trig,
    input  logic                       arb_in,
    output logic                       resp_valid,
    input  logic                       resp_ready,
`ifdef STABILITY_FLAG_EN
    output logic                       resp_stable,
`endif
    output logic                       resp,
    output logic [$clog2(NEVAL+1)-1:0] resp_ones
);

    localparam int OW   = $clog2(NEVAL + 1);
    localparam int EW   = (NEVAL > 1) ? $clog2(NEVAL) : 1;
    localparam int TMAX = (RESET_CYC > SETTLE) ? RESET_CYC : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    if ((NEVAL < 1) || ((NEVAL % 2) == 0)) begin : g_bad_neval
        $error("apuf_eval_ctrl: NEVAL must be odd and >= 1");
    end
    if (SETTLE < 3) begin : g_bad_settle
        $error("apuf_eval_ctrl: SETTLE must be >= 3");
    end
    if (RESET_CYC < 1) begin : g_bad_reset_cyc
        $error("apuf_eval_ctrl: RESET_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [EW-1:0]       eval_q, eval_d;
    logic [OW-1:0]       ones_q, ones_d;
    logic [NSTAGE-1:0]   chal_q, chal_d;
    logic                trig_q, trig_d;
    logic                rv_q, rv_d;
    logic                resp_q, resp_d;
    logic [OW-1:0]       ro_q, ro_d;
    logic                arb_meta_q, arb_sync_q;
`ifdef STABILITY_FLAG_EN
    logic                stable_q, stable_d;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        rv_d    = rv_q;
        resp_d  = resp_q;
        ro_d    = ro_q;
`ifdef STABILITY_FLAG_EN
        stable_d = stable_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (chal_valid) begin
                    chal_d  = chal;
                    ones_d  = '0;
                    eval_d  = '0;
                    tmr_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tmr_q == TW'(RESET_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = FIRE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            FIRE: begin
                if (tmr_q == TW'(SETTLE - 1)) begin
                    tmr_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SAMPLE: begin
                ones_d = ones_q + OW'(arb_sync_q);
                if (eval_q == EW'(NEVAL - 1)) begin
                    state_d = DONE;
                end else begin
                    eval_d  = eval_q + 1'b1;
                    state_d = ARM;
                end
            end
            DONE: begin
                // First DONE cycle registers the vote; the response is then
                // held until the consumer takes it.
                if (!rv_q) begin
                    rv_d   = 1'b1;
                    resp_d = (ones_q > OW'(NEVAL / 2));
                    ro_d   = ones_q;
`ifdef STABILITY_FLAG_EN
                    stable_d = (ones_q == '0) || (ones_q == OW'(NEVAL));
`endif
                end else if (resp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered from next state so the launch edge is glitch-free.
        trig_d = (state_d == FIRE) || (state_d == SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            eval_q     <= '0;
            ones_q     <= '0;
            chal_q     <= '0;
            trig_q     <= 1'b0;
            rv_q       <= 1'b0;
            resp_q     <= 1'b0;
            ro_q       <= '0;
            arb_meta_q <= 1'b0;
            arb_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            chal_q     <= chal_d;
            trig_q     <= trig_d;
            rv_q       <= rv_d;
            resp_q     <= resp_d;
            ro_q       <= ro_d;
            arb_meta_q <= arb_in;
            arb_sync_q <= arb_meta_q;
        end
    end

`ifdef STABILITY_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign resp_stable = stable_q;
`endif

    assign chal_ready = (state_q == IDLE);
    assign cT         = chal_q;
    assign cB         = chal_q;
    assign trig       = trig_q;
    assign resp_valid = rv_q;
    assign resp       = resp_q;
    assign resp_ones  = ro_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl at default parameters.
module tb_apuf_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chal_valid = 1'b0;
    logic        chal_ready;
    logic [15:0] chal = '0;
    logic [15:0] cT, cB;
    logic        trig;
    logic        arb_in = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp;
    logic [2:0]  resp_ones;
`ifdef STABILITY_FLAG_EN
    logic        resp_stable;
`endif

    apuf_eval_ctrl #(
        .NSTAGE   (16),
        .NEVAL    (7),
        .RESET_CYC(4),
        .SETTLE   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chal_valid(chal_valid),
        .chal_ready(chal_ready),
        .chal      (chal),
        .cT        (cT),
        .cB        (cB),
        .trig      (trig),
        .arb_in    (arb_in),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
`ifdef STABILITY_FLAG_EN
        .resp_stable(resp_stable),
`endif
        .resp      (resp),
        .resp_ones (resp_ones)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       resp;
        logic [2:0] ones;
        logic       stable;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] pat);
        exp_t e;
        int   c;
        c = $countones(pat);
        e.ones   = 3'(c);
        e.resp   = (c > 3);
        e.stable = (c == 0) || (c == 7);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (chal_ready) return;
            @(negedge clk);
        end
        check("ready_timeout", 32'(chal_ready), 32'd1);
    endtask

    // One full challenge: pat[i] is the arbiter value presented for evaluation i.
    task automatic run_chal(input logic [15:0] c, input logic [6:0] pat, input int hold);
        int   rises = 0, hi = 0, lo = 0, k;
        logic prev = 1'b0, ct_bad = 1'b0, busy_bad = 1'b0, hold_bad = 1'b0, seen = 1'b0;
        logic       held_resp;
        logic [2:0] held_ones;
        exp_t e;
        wait_ready();
        chal       = c;
        chal_valid = 1'b1;
        arb_in     = 1'b0;
        push_exp(pat);
        @(negedge clk);
        chal_valid = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            if (cT !== c || cB !== c) ct_bad = 1'b1;
            if (chal_ready !== 1'b0) busy_bad = 1'b1;
            if (trig && !prev) begin
                check("trig_low_ge4", 32'(lo >= 4), 32'd1);
                if (rises < 7) arb_in = pat[rises];
                rises++;
                hi = 0;
            end
            if (!trig && prev) begin
                check("trig_high_len", 32'(hi), 32'd9);
                lo = 0;
            end
            if (trig) hi++;
            else lo++;
            prev = trig;
            @(negedge clk);
        end
        check("resp_valid_seen", 32'(seen), 32'd1);
        check("latency", 32'(k), 32'd92);
        check("cT_cB_stable", 32'(ct_bad), 32'd0);
        check("busy_not_ready", 32'(busy_bad), 32'd0);
        check("trig_rises", 32'(rises), 32'd7);
        check("trig_low_in_done", 32'(trig), 32'd0);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("resp", 32'(resp), 32'(e.resp));
            check("resp_ones", 32'(resp_ones), 32'(e.ones));
`ifdef STABILITY_FLAG_EN
            check("resp_stable", 32'(resp_stable), 32'(e.stable));
`endif
        end
        held_resp = resp;
        held_ones = resp_ones;
        for (int h = 0; h < hold; h++) begin
            chal_valid = (h == 3);
            chal       = ~c;
            @(negedge clk);
            if (resp !== held_resp || resp_ones !== held_ones || resp_valid !== 1'b1 ||
                chal_ready !== 1'b0 || cT !== c) hold_bad = 1'b1;
        end
        chal_valid = 1'b0;
        if (hold > 0) check("done_hold", 32'(hold_bad), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_hs", 32'(chal_ready), 32'd1);
        check("valid_dropped", 32'(resp_valid), 32'd0);
        check("cT_kept", 32'(cT), 32'(c));
        @(negedge clk);
        check("nothing_queued", 32'(chal_ready), 32'd1);
    endtask

    task automatic reset_during_fire();
        logic fired = 1'b0;
        wait_ready();
        chal       = 16'h1234;
        chal_valid = 1'b1;
        @(negedge clk);
        chal_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trig) begin
                fired = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("fire_reached", 32'(fired), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_chal_ready", 32'(chal_ready), 32'd1);
        check("rst_cT", 32'(cT), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle", 32'(chal_ready), 32'd1);
        check("post_rst_trig", 32'(trig), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_chal_ready", 32'(chal_ready), 32'd1);
        check("reset_trig", 32'(trig), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp", 32'(resp), 32'd0);
        check("reset_resp_ones", 32'(resp_ones), 32'd0);
        check("reset_cT", 32'(cT), 32'd0);
        check("reset_cB", 32'(cB), 32'd0);
`ifdef STABILITY_FLAG_EN
        check("reset_resp_stable", 32'(resp_stable), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_chal(16'hA5A5, 7'b1111111, 10);
        run_chal(16'h3C3C, 7'b1010101, 0);
        run_chal(16'hC3C3, 7'b0101010, 0);
        run_chal(16'h0001, 7'b0000000, 2);
        reset_during_fire();
        run_chal(16'hFFFF, 7'b1111111, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
